// File: rtl/hourcnt.sv
// ---------------------------------------------------------------------------
// hourcnt - hour-of-day counter for the traffic simulator clock chain.
//
// Keeps the hour (00-23) in binary and in BCD, advances it on the minute
// counter's rollover pulse and on the manual hour-button pulse, emits a
// day-carry pulse on a natural midnight rollover, and classifies the hour
// into a traffic period for the signal-timing controller.
//
// Parameters
//   RST_HOUR     hour loaded on reset (0-23)
//   NIGHT_START  first hour of the night period
//   NIGHT_END    first hour after the night period
//
// Ports
//   clk        in   system clock, rising-edge
//   rst        in   asynchronous active-low reset
//   min_carry  in   one-cycle pulse on minute 59->00
//   hplus      in   one-cycle manual +1 hour pulse
//   hour_bin   out  [4:0] hour, binary 0-23
//   hour_tens  out  [1:0] BCD tens digit 0-2
//   hour_ones  out  [3:0] BCD ones digit 0-9
//   day_carry  out  one-cycle pulse on natural 23->00 rollover
//   period     out  [1:0] 00 night, 01 morning peak, 10 evening peak,
//                   11 normal
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module hourcnt #(
    parameter int RST_HOUR    = 0,
    parameter int NIGHT_START = 22,
    parameter int NIGHT_END   = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       min_carry,
    input  logic       hplus,
    output logic [4:0] hour_bin,
    output logic [1:0] hour_tens,
    output logic [3:0] hour_ones,
    output logic       day_carry,
    output logic [1:0] period
);

    typedef struct packed {
        logic [4:0] bin;
        logic [1:0] tens;
        logic [3:0] ones;
    } hour_t;

    localparam logic [1:0] PER_NIGHT   = 2'b00;
    localparam logic [1:0] PER_MORNING = 2'b01;
    localparam logic [1:0] PER_EVENING = 2'b10;
    localparam logic [1:0] PER_NORMAL  = 2'b11;

    // Night is tested first so it wins when the parameters overlap a peak.
    function automatic logic [1:0] period_of(input logic [4:0] h);
        int hv;
        hv = {27'd0, h};
        if (hv >= NIGHT_START || hv < NIGHT_END) begin
            return PER_NIGHT;
        end else if (hv >= 7 && hv <= 8) begin
            return PER_MORNING;
        end else if (hv >= 17 && hv <= 18) begin
            return PER_EVENING;
        end
        return PER_NORMAL;
    endfunction

    // +1 hour modulo 24 with the BCD digits carried alongside the binary
    // value, so no divider is needed to keep them in step.
    function automatic hour_t hour_inc(input hour_t h);
        hour_t r;
        if (h.bin == 5'd23) begin
            r.bin  = 5'd0;
            r.tens = 2'd0;
            r.ones = 4'd0;
        end else if (h.ones == 4'd9) begin
            r.bin  = h.bin + 5'd1;
            r.tens = h.tens + 2'd1;
            r.ones = 4'd0;
        end else begin
            r.bin  = h.bin + 5'd1;
            r.tens = h.tens;
            r.ones = h.ones + 4'd1;
        end
        return r;
    endfunction

    localparam logic [4:0] RST_BIN    = 5'(RST_HOUR);
    localparam logic [1:0] RST_TENS   = 2'(RST_HOUR / 10);
    localparam logic [3:0] RST_ONES   = 4'(RST_HOUR % 10);
    localparam logic [1:0] RST_PERIOD = period_of(RST_BIN);

    hour_t      hour_q, hour_d;
    logic       day_carry_q, day_carry_d;
    logic [1:0] period_q, period_d;

    hour_t      step1;
    logic       wrap1;

    // Minute rollover is applied first; only a wrap in that step counts as
    // a new day. The manual pulse then advances the result again.
    always_comb begin
        step1 = hour_q;
        wrap1 = 1'b0;
        if (min_carry) begin
            wrap1 = (hour_q.bin == 5'd23);
            step1 = hour_inc(hour_q);
        end

        hour_d = step1;
        if (hplus) begin
            hour_d = hour_inc(step1);
        end

        day_carry_d = wrap1;
        period_d    = period_of(hour_d.bin);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hour_q.bin  <= RST_BIN;
            hour_q.tens <= RST_TENS;
            hour_q.ones <= RST_ONES;
            day_carry_q <= 1'b0;
            period_q    <= RST_PERIOD;
        end else begin
            hour_q      <= hour_d;
            day_carry_q <= day_carry_d;
            period_q    <= period_d;
        end
    end

    assign hour_bin  = hour_q.bin;
    assign hour_tens = hour_q.tens;
    assign hour_ones = hour_q.ones;
    assign day_carry = day_carry_q;
    assign period    = period_q;

endmodule

// File: doc/hourcnt.md
# hourcnt

Hour-of-day counter for the traffic simulator clock chain. Consumes the one-cycle `hplus` pulse from the hour-button stage and the one-cycle rollover pulse from the minute counter. Maintains a 00–23 hour in binary and BCD, emits a day-carry pulse on natural midnight rollover, and classifies the hour into a traffic period code for the signal-timing controller.

## Interface
- `RST_HOUR`, default 0: hour loaded on reset; legal range 0–23.
- `NIGHT_START`, default 22: first hour of night period.
- `NIGHT_END`, default 6: first hour after night period.
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `min_carry`  input  1  one-cycle pulse from the minute counter on 59→00 rollover.
- `hplus`  input  1  one-cycle pulse from the hour-button stage; manual +1 hour.
- `hour_bin`  output  5  current hour, binary 0–23.
- `hour_tens`  output  2  BCD tens digit, 0–2.
- `hour_ones`  output  4  BCD ones digit, 0–9.
- `day_carry`  output  1  one-cycle pulse on natural 23→00 rollover.
- `period`  output  2  traffic period code: 00 night, 01 morning peak, 10 evening peak, 11 normal.

## Operation
- All outputs are registered. No combinational path from any input to any output.
- Reset: `hour_bin`=RST_HOUR, BCD digits match RST_HOUR, `day_carry`=0, `period`=code for RST_HOUR. With defaults, the reset values are 0, 0, 0, 0, and 00 (night).
- Per cycle, the next hour is computed from the current hour in two ordered steps:
  - Step 1: if `min_carry`=1, add 1 modulo 24.
  - Step 2: if `hplus`=1, add 1 modulo 24 to the result of step 1.
- Both pulses in the same cycle advance the hour by 2. Neither pulse is dropped.
- `day_carry`=1 in the cycle after step 1 wraps 23→00. Otherwise it is 0.
  - A wrap caused only by `hplus` never asserts `day_carry`. Manual setting does not advance the date.
  - Both pulses at hour 23: result 01, `day_carry`=1.
  - Both pulses at hour 22: result 00, `day_carry`=0.
- BCD tracking:
  - Ones digit wraps 9→0 and increments tens.
  - Transition 23→00 clears both digits.
  - BCD must always equal `hour_bin` in decimal. It is maintained by incremental logic, not by a divider.
- `period` is decoded from the next hour and registered alongside it, so it changes in the same cycle as `hour_bin`:
  - night (00): hour ≥ NIGHT_START or hour < NIGHT_END.
  - morning peak (01): 7 ≤ hour ≤ 8.
  - evening peak (10): 17 ≤ hour ≤ 18.
  - normal (11): all other hours.
  - Night takes priority if the parameters overlap a peak window.
- Pulses wider than one cycle are treated as repeated pulses, one increment per high cycle. Upstream stages guarantee single-cycle pulses.
- Reset asserted mid-operation immediately forces the reset values, including clearing an in-flight `day_carry`. The first update after reset release uses the pulses sampled on that edge.

## Timing
- Latency: a pulse sampled at edge N is reflected on all outputs after edge N; visible from cycle N+1.
- `day_carry` is high for exactly one cycle, coincident with `hour_bin` first reading 00 (or 01 in the double case).
- Throughput: one update per cycle. Back-to-back pulses on consecutive cycles each take effect.
- No idle states: the counter holds its value whenever both inputs are 0.

## Test plan
- **Reset:** drive `rst`=0 asynchronously mid-cycle. Required: `hour_bin`=0, tens=0, ones=0, `day_carry`=0, `period`=00 before the next edge.
- **Natural count:** apply 24 `min_carry` pulses from 0. Required:
  - `hour_bin` steps 1..23,0.
  - BCD reads 09→10 and 19→20 correctly.
  - `day_carry` pulses exactly once, on 23→00.
  - `period` reads 01 at hours 7–8, 10 at 17–18, 00 at 22–5, 11 elsewhere.
- **Manual wrap:** at hour 23, single `hplus`. Required: hour 00, `day_carry` stays 0.
- **Simultaneous pulses:**
  - At hour 23: required hour 01, `day_carry`=1 for one cycle.
  - At hour 22: required hour 00, `day_carry`=0.
  - At hour 9: required hour 11, tens=1, ones=1.
- **Back-to-back:** `hplus` high on 3 consecutive cycles from hour 5. Required: hours 6, 7, 8, with `period` changing 00→11→01→01.
- **Reset during carry:** at hour 23, assert `min_carry`, then assert `rst` in the following cycle. Required: `day_carry` forced to 0 and hour returns to RST_HOUR.
